// File: rtl/grf_wb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// grf_wb : general register file fed by the write-back stage of the 5-stage
//          MIPS pipeline.
//
// 32 x WIDTH registers, $0 reads as zero and is never written.
// Two combinational read ports serve ID. They bypass a same-cycle write, so ID
// sees the value WB is retiring in this cycle.
// One synchronous write port.
// A registered write trace and a saturating write-back counter are provided
// for debug and testbench scoreboarding.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   RA1 / RA2    read addresses (rs / rt)
//   RD1 / RD2    read data, zero-latency
//   WE/WA/WD     write enable / address / data from WB select
//   WPC          PC of the instruction in WB (trace only)
//   trace_valid  one-cycle pulse, a write was presented last cycle
//   trace_pc     PC of the traced write
//   trace_addr   register address of the traced write
//   trace_data   data of the traced write (0 when the target was $0)
//   wb_count     number of traced writes since reset, saturating
// -----------------------------------------------------------------------------
module grf_wb #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RA1,
    input  logic [4:0]       RA2,
    input  logic             WE,
    input  logic [4:0]       WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [31:0]      WPC,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [WIDTH-1:0] trace_data,
    output logic [CNT_W-1:0] wb_count
);

    // Entry 0 exists so every 5-bit address indexes in range. It is held at
    // zero by reset and is never written. Reads of $0 are forced to zero anyway.
    logic [WIDTH-1:0] r_regs [0:31];

    logic             r_trace_valid;
    logic [31:0]      r_trace_pc;
    logic [4:0]       r_trace_addr;
    logic [WIDTH-1:0] r_trace_data;
    logic [CNT_W-1:0] r_wb_count;

    logic             w_wr_en;
    logic             w_cnt_full;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    assign w_wr_en    = WE && (WA != 5'd0);
    assign w_cnt_full = (r_wb_count == {CNT_W{1'b1}});

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[WA] <= WD;
        end
    end

    // ------------------------------------------------------------------
    // Read ports.
    // Reset forces zero so a mid-cycle reset is visible at once. The bypass
    // compare needs no WA != 0 term, because RAn != 0 is already known there.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd1 = r_regs[RA1];
        if (reset || (RA1 == 5'd0)) begin
            w_rd1 = '0;
        end else if (WE && (WA == RA1)) begin
            w_rd1 = WD;
        end
    end

    always_comb begin
        w_rd2 = r_regs[RA2];
        if (reset || (RA2 == 5'd0)) begin
            w_rd2 = '0;
        end else if (WE && (WA == RA2)) begin
            w_rd2 = WD;
        end
    end

    assign RD1 = w_rd1;
    assign RD2 = w_rd2;

    // ------------------------------------------------------------------
    // Write trace.
    // Every WE is traced, including writes aimed at $0, so software-visible
    // retirement order is preserved. The data of such writes is reported as
    // the value $0 really holds.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= '0;
            r_trace_addr  <= '0;
            r_trace_data  <= '0;
        end else begin
            r_trace_valid <= WE;
            if (WE) begin
                r_trace_pc   <= WPC;
                r_trace_addr <= WA;
                r_trace_data <= (WA == 5'd0) ? '0 : WD;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-back counter, sticks at all-ones instead of wrapping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_count <= '0;
        end else if (WE && !w_cnt_full) begin
            r_wb_count <= r_wb_count + 1'b1;
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;
    assign wb_count    = r_wb_count;

endmodule

// File: tb/tb_grf_wb.sv
`timescale 1ns/1ps
module tb_grf_wb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  RA1 = '0, RA2 = '0, WA = '0;
    logic        WE = 1'b0;
    logic [31:0] WD = '0, WPC = '0;

    logic [31:0] RD1, RD2, trace_pc, trace_data, wb_count;
    logic        trace_valid;
    logic [4:0]  trace_addr;

    // second instance with a 3-bit counter for saturation
    logic [31:0] s_RD1, s_RD2, s_trace_pc, s_trace_data;
    logic        s_trace_valid;
    logic [4:0]  s_trace_addr;
    logic [2:0]  s_wb_count;

    int errors = 0;
    int checks = 0;

    // reference model
    logic [31:0] m_regs [32];
    logic        m_tv;
    logic [31:0] m_tpc, m_tdata;
    logic [4:0]  m_taddr;
    longint      m_writes;

    always #10 clk = ~clk;

    grf_wb u_dut (
        .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .WE(WE), .WA(WA),
        .WD(WD), .WPC(WPC), .RD1(RD1), .RD2(RD2), .trace_valid(trace_valid),
        .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
        .wb_count(wb_count)
    );

    grf_wb #(.WIDTH(32), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .WE(WE), .WA(WA),
        .WD(WD), .WPC(WPC), .RD1(s_RD1), .RD2(s_RD2), .trace_valid(s_trace_valid),
        .trace_pc(s_trace_pc), .trace_addr(s_trace_addr), .trace_data(s_trace_data),
        .wb_count(s_wb_count)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_tv = 1'b0; m_tpc = '0; m_taddr = '0; m_tdata = '0; m_writes = 0;
    endtask

    // what one rising edge does to the architectural state
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            if (WE && WA != 0) m_regs[WA] = WD;
            m_tv = WE;
            if (WE) begin
                m_tpc = WPC; m_taddr = WA; m_tdata = (WA == 0) ? 32'h0 : WD;
                m_writes++;
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (reset || ra == 0) return 32'h0;
        if (WE && WA == ra) return WD;
        return m_regs[ra];
    endfunction

    function automatic logic [2:0] exp_sat();
        return (m_writes > 7) ? 3'd7 : 3'(m_writes);
    endfunction

    // advance one clock: model follows the edge, sample 1ns later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        for (int a = 0; a < 32; a++) begin
            RA1 = 5'(a); RA2 = 5'(31 - a);
            WE = 1'b1; WA = 5'(a); WD = $urandom;
            #1;
            checks++;
            if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_read a=%0d: RD1=%h RD2=%h expected 0", a, RD1, RD2);
            end
        end
        checks++;
        if (trace_valid !== 1'b0 || wb_count !== 32'h0 || trace_pc !== 32'h0 ||
            trace_addr !== 5'h0 || trace_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_trace: tv=%b cnt=%0d pc=%h addr=%0d data=%h expected all 0",
                     trace_valid, wb_count, trace_pc, trace_addr, trace_data);
        end
        @(negedge clk);
        WE = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        WE = 1'b1; WA = 5'd5; WD = 32'h12345678; WPC = 32'h00003000; RA1 = 0; RA2 = 0;
        step();
        WE = 1'b0; RA1 = 5'd5;
        #1;
        checks++;
        if (RD1 !== 32'h12345678) begin
            errors++; $display("FAIL basic_read: RD1=%h expected 12345678", RD1);
        end
        checks++;
        if (trace_valid !== 1'b1 || trace_pc !== 32'h3000 || trace_addr !== 5'd5 ||
            trace_data !== 32'h12345678 || wb_count !== 32'd1) begin
            errors++;
            $display("FAIL basic_trace: tv=%b pc=%h addr=%0d data=%h cnt=%0d expected 1/3000/5/12345678/1",
                     trace_valid, trace_pc, trace_addr, trace_data, wb_count);
        end
        step();
    endtask

    task automatic test_bypass();
        WE = 1'b1; WA = 5'd8; WD = 32'hDEADBEEF; WPC = 32'h3004; RA1 = 5'd8; RA2 = 5'd8;
        #1;
        checks++;
        if (RD1 !== 32'hDEADBEEF || RD2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass: RD1=%h RD2=%h expected deadbeef", RD1, RD2);
        end
        step();
        WE = 1'b0;
        #1;
        checks++;
        if (RD1 !== 32'hDEADBEEF || RD2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_after: RD1=%h RD2=%h expected deadbeef", RD1, RD2);
        end
    endtask

    task automatic test_zero();
        WE = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF; WPC = 32'h3008; RA1 = 5'd0; RA2 = 5'd0;
        #1;
        checks++;
        if (RD1 !== 32'h0) begin
            errors++; $display("FAIL zero_same_cycle: RD1=%h expected 0", RD1);
        end
        step();
        WE = 1'b0;
        #1;
        checks++;
        if (RD1 !== 32'h0 || trace_valid !== 1'b1 || trace_addr !== 5'd0 ||
            trace_data !== 32'h0 || wb_count !== 32'd3 || trace_pc !== 32'h3008) begin
            errors++;
            $display("FAIL zero_after: RD1=%h tv=%b addr=%0d data=%h cnt=%0d pc=%h expected 0/1/0/0/3/3008",
                     RD1, trace_valid, trace_addr, trace_data, wb_count, trace_pc);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 4; i++) begin
            WE = 1'b1; WA = 5'(i); WD = 32'hA5A50000 + i; WPC = 32'h4000 + 4 * i;
            step();
        end
        WE = 1'b0; RA1 = 5'd1; RA2 = 5'd4;
        #1;
        checks++;
        if (RD1 !== 32'hA5A50001 || RD2 !== 32'hA5A50004) begin
            errors++; $display("FAIL async_prewrite: RD1=%h RD2=%h expected a5a50001/a5a50004", RD1, RD2);
        end
        #1;
        reset = 1'b1;          // between edges
        model_reset();
        for (int i = 1; i <= 4; i++) begin
            RA1 = 5'(i); RA2 = 5'(5 - i);
            #1;
            checks++;
            if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
                errors++; $display("FAIL async_read r%0d: RD1=%h RD2=%h expected 0", i, RD1, RD2);
            end
        end
        checks++;
        if (wb_count !== 32'h0 || trace_valid !== 1'b0) begin
            errors++; $display("FAIL async_state: cnt=%0d tv=%b expected 0/0", wb_count, trace_valid);
        end
        // write held during reset must be dropped
        WE = 1'b1; WA = 5'd2; WD = 32'h0BAD0BAD;
        step();
        WE = 1'b0;
        reset = 1'b0;          // released mid-cycle
        for (int i = 1; i <= 4; i++) begin
            RA1 = 5'(i);
            #1;
            checks++;
            if (RD1 !== 32'h0) begin
                errors++; $display("FAIL async_cleared r%0d: RD1=%h expected 0", i, RD1);
            end
        end
        // first write after release lands on the next edge
        WE = 1'b1; WA = 5'd3; WD = 32'h0000CAFE; WPC = 32'h5000;
        step();
        WE = 1'b0; RA1 = 5'd3; RA2 = 5'd2;
        #1;
        checks++;
        if (RD1 !== 32'h0000CAFE || RD2 !== 32'h0 || wb_count !== 32'd1) begin
            errors++;
            $display("FAIL async_first_write: RD1=%h RD2=%h cnt=%0d expected cafe/0/1", RD1, RD2, wb_count);
        end
    endtask

    task automatic test_saturation();
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (s_wb_count !== 3'd0) begin
            errors++; $display("FAIL sat_reset: cnt=%0d expected 0", s_wb_count);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            WE = 1'b1; WA = 5'((k % 31) + 1); WD = $urandom; WPC = 32'h6000 + 4 * k;
            step();
            checks++;
            if (s_wb_count !== ((k > 7) ? 3'd7 : 3'(k)) || wb_count !== 32'(k)) begin
                errors++;
                $display("FAIL sat_count k=%0d: sat=%0d main=%0d expected %0d/%0d",
                         k, s_wb_count, wb_count, (k > 7) ? 7 : k, k);
            end
        end
        WE = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            WE  = ($urandom_range(0, 9) < 7);
            WA  = 5'($urandom_range(0, 31));
            WD  = $urandom;
            WPC = $urandom;
            RA1 = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom_range(0, 31));
            RA2 = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (RD1 !== exp_rd(RA1) || RD2 !== exp_rd(RA2)) begin
                errors++;
                $display("FAIL rand_read n=%0d ra1=%0d ra2=%0d: RD1=%h RD2=%h expected %h/%h",
                         n, RA1, RA2, RD1, RD2, exp_rd(RA1), exp_rd(RA2));
            end
            step();
            checks++;
            if (trace_valid !== m_tv || trace_pc !== m_tpc || trace_addr !== m_taddr ||
                trace_data !== m_tdata || wb_count !== 32'(m_writes) || s_wb_count !== exp_sat()) begin
                errors++;
                $display("FAIL rand_trace n=%0d: tv=%b pc=%h addr=%0d data=%h cnt=%0d sat=%0d expected %b/%h/%0d/%h/%0d/%0d",
                         n, trace_valid, trace_pc, trace_addr, trace_data, wb_count, s_wb_count,
                         m_tv, m_tpc, m_taddr, m_tdata, m_writes, exp_sat());
            end
        end
        WE = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_zero();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grf_wb.md
Name: grf_wb

Overview:
- General register file that consumes the write-back word produced by the WB select stage, the last stage of the 5-stage MIPS pipeline.
- Provides 32 x WIDTH registers with $0 hardwired to zero, two combinational read ports for the ID stage, and one synchronous write port.
- Read ports bypass a same-cycle write internally, so ID sees the value being written back in that cycle.
- Emits a registered write trace and a saturating write-back counter for the testbench and debug.

Parameters:
- WIDTH, 32, data width of each register and of the write/read data.
- CNT_W, 32, width of the write-back counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- RA1  in  5  read address, port 1 (rs).
- RA2  in  5  read address, port 2 (rt).
- WE  in  1  write enable from the WB stage.
- WA  in  5  write address from the WB stage.
- WD  in  WIDTH  write data; the WB select output.
- WPC  in  32  PC of the instruction in WB, used for trace only.
- RD1  out  WIDTH  read data, port 1.
- RD2  out  WIDTH  read data, port 2.
- trace_valid  out  1  one-cycle pulse: a write was performed last cycle.
- trace_pc  out  32  PC of the traced write.
- trace_addr  out  5  register address of the traced write.
- trace_data  out  WIDTH  data of the traced write.
- wb_count  out  CNT_W  number of traced writes since reset, saturating.

Behaviour:
- Reset, asynchronous and active-high; while reset is high:
  - regs[1..31] = 0; writes blocked.
  - trace_valid = 0, trace_pc = 0, trace_addr = 0, trace_data = 0, wb_count = 0.
  - RD1 = RD2 = 0; bypass disabled.
- Reset released mid-cycle: the first write takes effect at the first rising edge with reset low.
- Write: at posedge, if WE and WA != 0, then regs[WA] <= WD.
  - WE with WA == 0 changes no register.
- Read is combinational, zero latency, evaluated per port n:
  - RAn == 0: RDn = 0.
  - Else if WE and WA == RAn: RDn = WD (internal bypass).
  - Else: RDn = regs[RAn].
- Both ports may read the same address; both bypass independently.
- Trace is registered, one cycle after the write edge:
  - trace_valid <= WE.
  - When WE: trace_pc <= WPC, trace_addr <= WA, trace_data <= (WA == 0 ? 0 : WD).
  - When !WE: trace_pc, trace_addr and trace_data hold their previous values.
- Counter: at posedge, if WE and wb_count != all-ones, then wb_count <= wb_count + 1; it saturates at 2^CNT_W - 1 and does not wrap.
- X or undefined WA/RA values are not supported; addresses are always 5-bit valid.
- No internal state besides the register array, the trace registers and wb_count.

Test Plan:
- Reset check: assert reset, then read all 32 addresses on both ports -> every RD = 0; trace_valid = 0; wb_count = 0.
- Basic write/read: write WA=5, WD=0x12345678, WPC=0x00003000; next cycle RA1=5 -> RD1 = 0x12345678; trace_valid = 1, trace_pc = 0x3000, trace_addr = 5, trace_data = 0x12345678; wb_count = 1.
- Same-cycle bypass: write WA=8, WD=0xDEADBEEF while RA1=RA2=8 (old value 0) -> RD1 = RD2 = 0xDEADBEEF in that same cycle.
- $0 protection: WE=1, WA=0, WD=0xFFFFFFFF with RA1=0 -> RD1 = 0 in that cycle and after; trace_valid = 1, trace_addr = 0, trace_data = 0; wb_count increments.
- Asynchronous reset mid-stream: write regs 1..4, then assert reset between clock edges -> RD for regs 1..4 is 0 immediately, before the next edge; wb_count = 0; a write with WE held during reset is ignored.
- Saturation: CNT_W=3, apply 10 consecutive writes -> wb_count reads 1..7 and then holds at 7.
